inst_fetch_queue: RTL
=====================

// Module: inst_fetch_queue
// PURPOSE
// - Parametrised instruction-fetch front end for the 5-stage cpu core. It replaces the raw i_inst input and the bare pc register.
// - Issues in-order word requests to instruction memory, with variable latency and up to DEPTH outstanding.
// - Buffers returned instructions, each tagged with its pc, in a DEPTH-entry prefetch queue. Decode drains the queue with a valid/ready handshake.
// - A redirect from the ALU stage (branch taken, jal, jalr) flushes the queue and squashes responses still in flight.
// PARAMETERS
// - XLEN      32  pc / address width
// - INST_W    32  instruction width
// - DEPTH     4   queue entries = max outstanding + buffered; power of 2, >=2
// - PC_STEP   1   pc increment per fetch (word-addressed imem)
// - RESET_PC  0   first fetch address after reset
// PORTS
// - i_clk           in   1       clock, rising edge
// - i_rst           in   1       asynchronous, active-high reset
// - i_start         in   1       fetch enable; low = issue no new requests
// - o_imem_req      out  1       request valid
// - o_imem_addr     out  XLEN    request address
// - i_imem_gnt      in   1       request accepted this cycle (o_imem_req & i_imem_gnt)
// - i_imem_rvalid   in   1       response valid; responses return in request order
// - i_imem_rdata    in   INST_W  response instruction
// - i_redirect      in   1       redirect fetch (branch/jump resolved)
// - i_redirect_pc   in   XLEN    new fetch pc
// - o_valid         out  1       queue head valid
// - o_inst          out  INST_W  head instruction
// - o_pc            out  XLEN    head pc
// - i_ready         in   1       decode consumes head (pop when o_valid & i_ready)
// - o_squash_busy   out  1       stale responses are still being dropped
// BEHAVIOUR
// - Reset (async, high):
//   - fetch_pc = rsp_pc = RESET_PC
//   - count = outstanding = drop_cnt = 0
//   - o_imem_req = 0, o_valid = 0, o_squash_busy = 0
//   - o_inst and o_pc read 0
//   - reset mid-transaction abandons in-flight responses; no drop tracking survives reset
// - Counters: count, outstanding and drop_cnt are each $clog2(DEPTH)+1 bits.
// - Issue (combinational o_imem_req):
//   - o_imem_req = i_start & !i_redirect & (count + outstanding + drop_cnt < DEPTH)
//   - o_imem_addr = fetch_pc
//   - accept: fetch_pc += PC_STEP (modulo 2^XLEN, wraps silently); outstanding++
// - Response (i_imem_rvalid):
//   - outstanding-- (or drop_cnt-- while drop_cnt != 0)
//   - if drop_cnt != 0: data discarded
//   - else: push {rsp_pc, rdata}; rsp_pc += PC_STEP
// - Pop: o_valid & i_ready removes the head. Minimum latency from response to o_valid is 1 cycle; there is no bypass.
// - Same cycle:
//   - accept, response and pop may all coincide; counters net correctly
//   - push to a full queue cannot occur because the credit rule reserves space; the bench asserts on it
// - Redirect, highest priority, effective at the next edge:
//   - queue emptied; o_valid = 0 the following cycle
//   - fetch_pc = rsp_pc = i_redirect_pc
//   - no request is issued in the redirect cycle
//   - drop_cnt = outstanding + drop_cnt - (rvalid this cycle); a response arriving in the redirect cycle is discarded
//   - pop in the redirect cycle is ignored
// - Back-to-back redirects: each redirect re-targets pc; drop_cnt accumulates, never underflows.
// - o_squash_busy = (drop_cnt != 0), registered.
// - i_start low: outstanding responses still complete and enqueue; the queue still drains.
// - i_imem_rvalid with outstanding + drop_cnt == 0 is illegal (assertion).
// STRUCTURE
// - cpu_pkg (shared):
//   - XLEN / INST_W localparams
//   - NOP_INST = 32'h00000013
//   - fetch_entry_t struct {pc, inst}
// - Sub-module fetch_fifo:
//   - DEPTH-entry circular buffer of fetch_entry_t
//   - rd/wr pointers + count, synchronous flush input
//   - parent owns credit/drop logic
// TESTING
// - Reset: i_rst pulsed, i_start=1, gnt=1, 1-cycle memory -> addresses 0,1,2,3 issued; o_pc 0,1,2,3 with matching inst; o_valid first high 2 cycles after first req.
// - Backpressure: i_ready=0, DEPTH=4 -> exactly 4 accepts, then o_imem_req=0; i_ready=1 -> one new req per pop.
// - Redirect with 3 outstanding (3-cycle memory): i_redirect_pc=0x40 -> next req addr 0x40, 3 stale responses dropped, o_squash_busy high 3 cycles, first o_pc=0x40.
// - Redirect coincident with rvalid and pop -> that response is dropped, queue empty next cycle, drop_cnt correct.
// - Wrap: fetch_pc=32'hFFFF_FFFF -> next addr 0, o_pc sequence FFFF_FFFF, 0.
// - Async reset asserted mid-burst -> all outputs 0 within the same cycle; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/inst_fetch_queue_pkg.sv
// Shared types and widths for the instruction-fetch front end.
// The helper sizes the occupancy counters so that the value DEPTH itself fits.
package inst_fetch_queue_pkg;

    localparam int XLEN   = 32;
    localparam int INST_W = 32;

    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch front-end bus: instruction-memory request/response, redirect and decode handshake.
// slave = the fetch queue, master = the core/memory side driving it.
interface inst_fetch_queue_if import inst_fetch_queue_pkg::*; ();

    logic              i_start;
    logic              o_imem_req;
    logic [XLEN-1:0]   o_imem_addr;
    logic              i_imem_gnt;
    logic              i_imem_rvalid;
    logic [INST_W-1:0] i_imem_rdata;
    logic              i_redirect;
    logic [XLEN-1:0]   i_redirect_pc;
    logic              o_valid;
    logic [INST_W-1:0] o_inst;
    logic [XLEN-1:0]   o_pc;
    logic              i_ready;
    logic              o_squash_busy;

    modport slave (
        input  i_start, i_imem_gnt, i_imem_rvalid, i_imem_rdata,
               i_redirect, i_redirect_pc, i_ready,
        output o_imem_req, o_imem_addr, o_valid, o_inst, o_pc, o_squash_busy
    );

    modport master (
        output i_start, i_imem_gnt, i_imem_rvalid, i_imem_rdata,
               i_redirect, i_redirect_pc, i_ready,
        input  o_imem_req, o_imem_addr, o_valid, o_inst, o_pc, o_squash_busy
    );

endinterface

// File: rtl/inst_fetch_queue_fifo.sv
// DEPTH-entry circular buffer of fetched {pc, inst} pairs with a synchronous flush.
// The head is read combinationally and forced to zero while the buffer is empty.
module fetch_fifo import inst_fetch_queue_pkg::*; #(
    parameter  int DEPTH = 4,
    localparam int CW    = cnt_w(DEPTH)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_flush,
    input  logic         i_push,
    input  fetch_entry_t i_wdata,
    input  logic         i_pop,
    output logic         o_valid,
    output fetch_entry_t o_rdata,
    output logic [CW-1:0] o_count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  entry_q [DEPTH];
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    // Flush wins over both push and pop in the same cycle.
    assign do_push = i_push && !i_flush;
    assign do_pop  = i_pop && (count_q != '0) && !i_flush;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (i_flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            entry_q[wr_ptr_q] <= i_wdata;
        end
    end

    assign o_valid = (count_q != '0);
    assign o_rdata = o_valid ? entry_q[rd_ptr_q] : '0;
    assign o_count = count_q;

    assert property (@(posedge i_clk) disable iff (i_rst)
        do_push |-> (count_q < CW'(DEPTH)));

endmodule

// File: rtl/inst_fetch_queue.sv
// In-order instruction prefetcher: issues word requests under a credit limit,
// tags responses with their pc, and squashes in-flight responses on redirect.
module inst_fetch_queue import inst_fetch_queue_pkg::*; #(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] PC_STEP  = 1,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    inst_fetch_queue_if.slave  bus
);

    localparam int CW = cnt_w(DEPTH);
    localparam int SW = CW + 2;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic            squash_busy_q;
    logic [CW-1:0]   count;
    logic [CW-1:0]   inflight;
    logic [SW-1:0]   in_use;
    logic            accept;
    logic            rsp_drop;
    logic            rsp_keep;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;

    // Every queued, outstanding or doomed word holds a slot, so a response always has room.
    assign inflight = outstanding_q + drop_cnt_q;
    assign in_use   = SW'(count) + SW'(outstanding_q) + SW'(drop_cnt_q);

    assign bus.o_imem_req  = !i_rst && bus.i_start && !bus.i_redirect && (in_use < SW'(DEPTH));
    assign bus.o_imem_addr = fetch_pc_q;

    assign accept   = bus.o_imem_req && bus.i_imem_gnt;
    assign rsp_drop = bus.i_imem_rvalid && (drop_cnt_q != '0);
    assign rsp_keep = bus.i_imem_rvalid && (drop_cnt_q == '0) && !bus.i_redirect;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        if (bus.i_redirect) begin
            fetch_pc_d    = bus.i_redirect_pc;
            rsp_pc_d      = bus.i_redirect_pc;
            outstanding_d = '0;
            // Everything still in flight becomes stale; a response landing now is one of them.
            if (inflight != '0) begin
                drop_cnt_d = inflight - CW'(bus.i_imem_rvalid);
            end else begin
                drop_cnt_d = '0;
            end
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
            if (rsp_keep) begin
                rsp_pc_d = rsp_pc_q + PC_STEP;
            end
            if (rsp_drop) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
            outstanding_d = outstanding_q + CW'(accept) - CW'(rsp_keep);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            squash_busy_q <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            squash_busy_q <= (drop_cnt_d != '0);
        end
    end

    assign push_entry.pc   = rsp_pc_q;
    assign push_entry.inst = bus.i_imem_rdata;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (bus.i_redirect),
        .i_push  (rsp_keep),
        .i_wdata (push_entry),
        .i_pop   (bus.i_ready),
        .o_valid (bus.o_valid),
        .o_rdata (head_entry),
        .o_count (count)
    );

    assign bus.o_inst        = head_entry.inst;
    assign bus.o_pc          = head_entry.pc;
    assign bus.o_squash_busy = squash_busy_q;

    assert property (@(posedge i_clk) disable iff (i_rst)
        bus.i_imem_rvalid |-> (inflight != '0));

endmodule
